byte_hist_rx: RTL and testbench

BYTE_HIST_RX -- requirements
Module: byte_hist_rx

---
 rtl/byte_hist_rx.sv | 124 ++++++++++++
 tb/tb_byte_hist_rx.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/byte_hist_rx.sv
// 8N1 serial receiver that keeps the last three received bytes as a shift history.
// Sampling is timed from the synchronized falling edge of the start bit (E0).
module byte_hist_rx #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rxd,
    input  logic       hist_clr,
    output logic [7:0] Trig_1,
    output logic [7:0] Trig_2,
    output logic [7:0] Trig_3,
    output logic       priem,
    output logic       frame_err
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT/2 - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HI} state_t;

    state_t        state, state_nx;
    logic          rxd_m, rxd_s, rxd_p;
    logic [CW-1:0] cnt, cnt_nx;
    logic [2:0]    bit_idx, bit_nx;
    logic [7:0]    sh;
    logic          shift, byte_ok, byte_err;

    // Sync flops reset low so a line held low across reset never looks like a start edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rxd_m <= 1'b0;
            rxd_s <= 1'b0;
            rxd_p <= 1'b0;
        end else begin
            rxd_m <= rxd;
            rxd_s <= rxd_m;
            rxd_p <= rxd_s;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt + 1'b1;
        bit_nx   = bit_idx;
        shift    = 1'b0;
        byte_ok  = 1'b0;
        byte_err = 1'b0;
        case (state)
            IDLE: begin
                cnt_nx = '0;
                if (rxd_p && !rxd_s) begin
                    state_nx = START;
                    bit_nx   = '0;
                end
            end
            START: begin
                if (cnt == HALF_M1) begin
                    cnt_nx   = '0;
                    state_nx = rxd_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (cnt == FULL_M1) begin
                    cnt_nx = '0;
                    shift  = 1'b1;
                    bit_nx = bit_idx + 1'b1;
                    if (bit_idx == 3'd7) state_nx = STOP;
                end
            end
            STOP: begin
                if (cnt == FULL_M1) begin
                    cnt_nx = '0;
                    if (rxd_s) begin
                        byte_ok  = 1'b1;
                        state_nx = IDLE;
                    end else begin
                        byte_err = 1'b1;
                        state_nx = WAIT_HI;
                    end
                end
            end
            WAIT_HI: begin
                cnt_nx = '0;
                if (rxd_s) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            bit_idx   <= '0;
            sh        <= '0;
            priem     <= 1'b0;
            frame_err <= 1'b0;
            Trig_1    <= '0;
            Trig_2    <= '0;
            Trig_3    <= '0;
        end else begin
            cnt       <= cnt_nx;
            bit_idx   <= bit_nx;
            priem     <= byte_ok;
            frame_err <= byte_err;
            if (shift) sh <= {rxd_s, sh[7:1]};
            // A clear landing on the stop sample keeps only the new byte.
            if (byte_ok) begin
                Trig_1 <= sh;
                Trig_2 <= hist_clr ? 8'h00 : Trig_1;
                Trig_3 <= hist_clr ? 8'h00 : Trig_2;
            end else if (hist_clr) begin
                Trig_1 <= '0;
                Trig_2 <= '0;
                Trig_3 <= '0;
            end
        end
    end
endmodule

// File: tb/tb_byte_hist_rx.sv
// Directed bench for byte_hist_rx: frame timing, history shifting, glitch, framing error,
// mid-frame reset and history clear.
module tb_byte_hist_rx;
    localparam int CPB = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rxd = 1'b1;
    logic       hist_clr = 1'b0;
    logic [7:0] Trig_1, Trig_2, Trig_3;
    logic       priem, frame_err;

    int n_chk = 0;
    int n_err = 0;
    int cyc = 0;
    int priem_cnt = 0;
    int ferr_cnt = 0;
    int both_cnt = 0;
    int last_priem_cyc = 0;

    byte_hist_rx #(.CLKS_PER_BIT(CPB)) dut (
        .clk(clk), .rst_n(rst_n), .rxd(rxd), .hist_clr(hist_clr),
        .Trig_1(Trig_1), .Trig_2(Trig_2), .Trig_3(Trig_3),
        .priem(priem), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (priem) begin
            priem_cnt <= priem_cnt + 1;
            last_priem_cyc <= cyc;
        end
        if (frame_err) ferr_cnt <= ferr_cnt + 1;
        if (priem && frame_err) both_cnt <= both_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Called on a negedge; leaves rxd at the stop-bit level.
    task automatic send_byte(input logic [7:0] d, input logic stop_bit);
        rxd = 1'b0;
        idle(CPB);
        for (int i = 0; i < 8; i++) begin
            rxd = d[i];
            idle(CPB);
        end
        rxd = stop_bit;
        idle(CPB);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        rxd = 1'b1;
        idle(4);
        rst_n = 1'b1;
        idle(4);
    endtask

    initial begin
        int p0, f0, t0;

        // reset state
        idle(3);
        check("rst_trig1", Trig_1, 8'h00);
        check("rst_trig2", Trig_2, 8'h00);
        check("rst_trig3", Trig_3, 8'h00);
        check("rst_priem", priem, 1'b0);
        check("rst_ferr", frame_err, 1'b0);
        rst_n = 1'b1;
        idle(5);

        // single frame latency: priem seen 155 edges after rxd falls
        p0 = priem_cnt;
        t0 = cyc;
        send_byte(8'h1B, 1'b1);
        idle(4);
        check("lat_pcnt", priem_cnt - p0, 1);
        check("lat_cyc", last_priem_cyc - t0, 155);
        check("lat_trig1", Trig_1, 8'h1B);

        // back-to-back frames after reset
        do_reset();
        p0 = priem_cnt;
        send_byte(8'h1B, 1'b1);
        send_byte(8'h5B, 1'b1);
        send_byte(8'h33, 1'b1);
        idle(4);
        check("b2b_pcnt", priem_cnt - p0, 3);
        check("b2b_trig1", Trig_1, 8'h33);
        check("b2b_trig2", Trig_2, 8'h5B);
        check("b2b_trig3", Trig_3, 8'h1B);

        // 3-cycle glitch rejected, then a normal frame
        p0 = priem_cnt;
        f0 = ferr_cnt;
        rxd = 1'b0;
        idle(3);
        rxd = 1'b1;
        idle(40);
        check("gl_pcnt", priem_cnt - p0, 0);
        check("gl_fcnt", ferr_cnt - f0, 0);
        send_byte(8'hA5, 1'b1);
        idle(4);
        check("gl_a5_pcnt", priem_cnt - p0, 1);
        check("gl_trig1", Trig_1, 8'hA5);
        check("gl_trig2", Trig_2, 8'h33);
        check("gl_trig3", Trig_3, 8'h5B);

        // framing error, long low line, then recovery
        p0 = priem_cnt;
        f0 = ferr_cnt;
        send_byte(8'h5B, 1'b0);
        idle(40);
        check("fe_fcnt", ferr_cnt - f0, 1);
        check("fe_pcnt", priem_cnt - p0, 0);
        check("fe_trig1", Trig_1, 8'hA5);
        check("fe_trig2", Trig_2, 8'h33);
        check("fe_trig3", Trig_3, 8'h5B);
        rxd = 1'b1;
        idle(2 * CPB);
        send_byte(8'h33, 1'b1);
        idle(4);
        check("fe_rec_pcnt", priem_cnt - p0, 1);
        check("fe_rec_fcnt", ferr_cnt - f0, 1);
        check("fe_rec_trig1", Trig_1, 8'h33);
        check("fe_rec_trig2", Trig_2, 8'hA5);

        // hist_clr coincident with the stop sample
        do_reset();
        send_byte(8'h1B, 1'b1);
        idle(4);
        check("hc_pre_trig1", Trig_1, 8'h1B);
        p0 = priem_cnt;
        fork
            send_byte(8'h5B, 1'b1);
            begin
                idle(154);
                hist_clr = 1'b1;
                idle(1);
                hist_clr = 1'b0;
            end
        join
        idle(4);
        check("hc_es_pcnt", priem_cnt - p0, 1);
        check("hc_es_trig1", Trig_1, 8'h5B);
        check("hc_es_trig2", Trig_2, 8'h00);
        check("hc_es_trig3", Trig_3, 8'h00);

        // hist_clr mid-frame clears at once and leaves the frame intact
        p0 = priem_cnt;
        fork
            send_byte(8'h33, 1'b1);
            begin
                idle(50);
                hist_clr = 1'b1;
                idle(1);
                hist_clr = 1'b0;
                check("hc_mid_trig1", Trig_1, 8'h00);
            end
        join
        idle(4);
        check("hc_mid_pcnt", priem_cnt - p0, 1);
        check("hc_mid_rx_trig1", Trig_1, 8'h33);
        check("hc_mid_rx_trig2", Trig_2, 8'h00);

        // reset during bit 4 with line held low
        rxd = 1'b0;
        idle(CPB);
        for (int i = 0; i < 4; i++) begin
            rxd = (8'hFF >> i) & 1'b1;
            idle(CPB);
        end
        rxd = 1'b0;
        rst_n = 1'b0;
        #1;
        check("mr_async_trig1", Trig_1, 8'h00);
        idle(5);
        check("mr_priem", priem, 1'b0);
        rst_n = 1'b1;
        p0 = priem_cnt;
        f0 = ferr_cnt;
        idle(300);
        check("mr_pcnt", priem_cnt - p0, 0);
        check("mr_fcnt", ferr_cnt - f0, 0);
        check("mr_trig1", Trig_1, 8'h00);
        check("mr_trig3", Trig_3, 8'h00);
        rxd = 1'b1;
        idle(20);
        send_byte(8'hA5, 1'b1);
        idle(4);
        check("mr_rx_pcnt", priem_cnt - p0, 1);
        check("mr_rx_trig1", Trig_1, 8'hA5);

        check("excl_strobes", both_cnt, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
